// File: rtl/divisor_frequencia_multicanal_pkg.sv
// divisor_frequencia_multicanal_pkg: shared defaults and ratio helpers for the divider, timer and display blocks
package divisor_frequencia_multicanal_pkg;
  localparam int N_CH_DEF = 2;
  localparam int DIV_W_DEF = 16;
  localparam logic [31:0] DEFAULT_DIV_RAW = 32'd65536;
  // A stored ratio of zero behaves as divide-by-1
  function automatic logic [31:0] eff_ratio(input logic [31:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/divisor_frequencia_multicanal_if.sv
// divisor_frequencia_multicanal_if: enable, ratio-programming and tick/clk_div bundle
interface divisor_frequencia_multicanal_if
  import divisor_frequencia_multicanal_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int DIV_W = DIV_W_DEF
) ();
  localparam int CH_W = ch_w(N_CH);
  logic en;
  logic cfg_we;
  logic [CH_W-1:0] cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [N_CH-1:0] tick;
  logic [N_CH-1:0] clk_div;
  modport master (output en, cfg_we, cfg_ch, cfg_div, input tick, clk_div);
  modport slave (input en, cfg_we, cfg_ch, cfg_div, output tick, clk_div);
endinterface

// File: rtl/divisor_frequencia_multicanal_canal.sv
// divisor_canal: one divider channel with ratio register, counter, registered tick and toggle
module divisor_canal
  import divisor_frequencia_multicanal_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter logic [DIV_W-1:0] RST_DIV = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_val_i,
  output logic             tick_o,
  output logic             clk_div_o
);
  logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
  logic tick_q, tick_d, clk_div_q, clk_div_d, wrap;
  // A load restarts the count and suppresses a coinciding wrap
  always_comb begin
    wrap = step_i && (cnt_q == DIV_W'(eff_ratio(32'(div_q)) - 32'd1));
    div_d = load_i ? load_val_i : div_q;
    cnt_d = (load_i || wrap) ? '0 : cnt_q + DIV_W'(step_i);
    tick_d = wrap && !load_i;
    clk_div_d = clk_div_q ^ tick_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= RST_DIV;
      cnt_q <= '0;
      tick_q <= 1'b0;
      clk_div_q <= 1'b0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
      tick_q <= tick_d;
      clk_div_q <= clk_div_d;
    end
  end
  assign tick_o = tick_q;
  assign clk_div_o = clk_div_q;
endmodule

// File: rtl/divisor_frequencia_multicanal.sv
// divisor_frequencia_multicanal: N_CH tick/square-wave enable dividers, optionally cascaded
module divisor_frequencia_multicanal
  import divisor_frequencia_multicanal_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int DIV_W = DIV_W_DEF,
  parameter int CASCADE = 1,
  parameter logic [31:0] DEFAULT_DIV = DEFAULT_DIV_RAW
) (
  input logic clk,
  input logic rst_n,
  divisor_frequencia_multicanal_if.slave bus
);
  localparam int CH_W = ch_w(N_CH);
  logic [N_CH-1:0] tick, clk_div, src, load;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // Channel selects outside 0..N_CH-1 decode to no load at all
    if (i == 0 || CASCADE == 0) begin : g_en
      assign src[i] = bus.en;
    end else begin : g_cas
      assign src[i] = tick[i-1];
    end
    assign load[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
    divisor_canal #(
      .DIV_W(DIV_W),
      .RST_DIV(DIV_W'(DEFAULT_DIV))
    ) u_canal (
      .clk(clk),
      .rst_n(rst_n),
      .step_i(src[i]),
      .load_i(load[i]),
      .load_val_i(bus.cfg_div),
      .tick_o(tick[i]),
      .clk_div_o(clk_div[i])
    );
  end
  assign bus.tick = tick;
  assign bus.clk_div = clk_div;
endmodule
